// File: rtl/jpeg_byte_stuffer.sv
// jpeg_byte_stuffer
// Drains 32-bit words from the entropy-coder output FIFO, emits them MSB-first
// as a valid/ready byte stream and inserts a 0x00 after every 0xFF data byte.
// Also keeps a saturating count of stuffing bytes and a sticky flag for read
// data that arrives when no read is outstanding.

module jpeg_byte_stuffer #(
    parameter int STUFF_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_empty,
    input  logic [31:0]            fifo_read_data,
    input  logic                   fifo_rdata_valid,
    output logic                   fifo_read_req,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic [STUFF_CNT_W-1:0] stuff_cnt,
    output logic                   proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SEND  = 2'd2,
        ST_STUFF = 2'd3
    } state_t;

    localparam logic [STUFF_CNT_W-1:0] CNT_ONE = {{(STUFF_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STUFF_CNT_W-1:0] CNT_MAX = {STUFF_CNT_W{1'b1}};

    state_t                 state_r;
    state_t                 next_state_s;
    logic [1:0]             idx_r;
    logic [1:0]             idx_next_s;
    logic [31:0]            word_r;
    logic [31:0]            word_next_s;
    logic                   byte_valid_r;
    logic                   byte_valid_next_s;
    logic [7:0]             byte_data_r;
    logic [7:0]             byte_data_next_s;
    logic [STUFF_CNT_W-1:0] stuff_cnt_r;
    logic                   proto_err_r;
    logic [7:0]             cur_byte_s;
    logic                   accept_s;
    logic                   read_req_s;
    logic                   stuff_inc_s;
    logic                   perr_set_s;

    // Byte currently addressed in the held word, and downstream acceptance.
    assign cur_byte_s = word_r[{idx_r, 3'b000} +: 8];
    assign accept_s   = byte_valid_r && byte_ready;

    // Only IDLE may request; gating with rst_n keeps the request low in reset.
    assign read_req_s    = rst_n && (state_r == ST_IDLE) && !fifo_empty;
    assign fifo_read_req = read_req_s;

    assign byte_valid = byte_valid_r;
    assign byte_data  = byte_data_r;
    assign stuff_cnt  = stuff_cnt_r;
    assign proto_err  = proto_err_r;

    // State, byte index and held word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            word_r  <= 32'd0;
        end else begin
            state_r <= next_state_s;
            idx_r   <= idx_next_s;
            word_r  <= word_next_s;
        end
    end

    // Next-state logic: read, serialize MSB-first, detour through STUFF after 0xFF.
    always_comb begin
        next_state_s = state_r;
        idx_next_s   = idx_r;
        word_next_s  = word_r;
        case (state_r)
            ST_IDLE: begin
                if (read_req_s) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (fifo_rdata_valid) begin
                    word_next_s  = fifo_read_data;
                    idx_next_s   = 2'd3;
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_SEND: begin
                if (!accept_s) begin
                    next_state_s = ST_SEND;
                end else if (cur_byte_s == 8'hFF) begin
                    next_state_s = ST_STUFF;
                end else if (idx_r == 2'd0) begin
                    next_state_s = ST_IDLE;
                end else begin
                    idx_next_s   = idx_r - 2'd1;
                    next_state_s = ST_SEND;
                end
            end
            ST_STUFF: begin
                if (!accept_s) begin
                    next_state_s = ST_STUFF;
                end else if (idx_r == 2'd0) begin
                    next_state_s = ST_IDLE;
                end else begin
                    idx_next_s   = idx_r - 2'd1;
                    next_state_s = ST_SEND;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                idx_next_s   = 2'd0;
            end
        endcase
    end

    // Output decode: byte stream values for the next cycle plus event strobes.
    always_comb begin
        byte_valid_next_s = 1'b0;
        byte_data_next_s  = 8'h00;
        case (next_state_s)
            ST_SEND: begin
                byte_valid_next_s = 1'b1;
                byte_data_next_s  = word_next_s[{idx_next_s, 3'b000} +: 8];
            end
            ST_STUFF: begin
                byte_valid_next_s = 1'b1;
                byte_data_next_s  = 8'h00;
            end
            default: begin
                byte_valid_next_s = 1'b0;
                byte_data_next_s  = 8'h00;
            end
        endcase
        stuff_inc_s = (state_r == ST_STUFF) && accept_s;
        perr_set_s  = fifo_rdata_valid && (state_r != ST_WAIT);
    end

    // Registered byte stream outputs; independent of byte_ready in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_valid_r <= 1'b0;
            byte_data_r  <= 8'h00;
        end else begin
            byte_valid_r <= byte_valid_next_s;
            byte_data_r  <= byte_data_next_s;
        end
    end

    // Saturating stuffing-byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuff_cnt_r <= {STUFF_CNT_W{1'b0}};
        end else if (stuff_inc_s && (stuff_cnt_r != CNT_MAX)) begin
            stuff_cnt_r <= stuff_cnt_r + CNT_ONE;
        end else begin
            stuff_cnt_r <= stuff_cnt_r;
        end
    end

    // Sticky flag for read data that arrives with no read outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_r <= 1'b0;
        end else if (perr_set_s) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

endmodule
